// File: rtl/process_scheduler.sv
// Round-robin process scheduler: slot store plus IDLE/RUN/SAVE/SELECT/LOAD switch FSM.
// Latency: quantum/halt at edge t -> ctx strobe in the cycle after edge t+2; back in RUN after t+3.
// Backpressure: create_ready_o drops while every slot is occupied; quantum/halt outside RUN are dropped.
module process_scheduler #(
  parameter int NPROC = 4,
  parameter int AW    = 32,
  parameter int QW    = 32,
  localparam int PW   = (NPROC > 1) ? $clog2(NPROC) : 1
) (
  input  logic          clk_i,
  input  logic          reset_i,
  input  logic          quantum_i,
  input  logic          halt_proc_i,
  input  logic [AW-1:0] save_pc_i,
  input  logic          create_valid_i,
  output logic          create_ready_o,
  input  logic [AW-1:0] create_pc_i,
  input  logic [AW-1:0] create_base_i,
  input  logic [QW-1:0] create_qtm_i,
  output logic          ctx_o,
  output logic [AW-1:0] resume_pc_o,
  output logic [AW-1:0] base_addr_o,
  output logic          tq_load_o,
  output logic [QW-1:0] tq_value_o,
  output logic [PW-1:0] cur_pid_o,
  output logic          running_o,
  output logic          all_idle_o
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_RUN,
    S_SAVE,
    S_SELECT,
    S_LOAD
  } state_t;

  state_t              state_q;
  logic                halt_q;      // switch reason: 1 = halt, 0 = quantum expiry
  logic [PW-1:0]       start_q;     // first slot index examined by SELECT
  logic [PW-1:0]       cur_pid_q;
  logic                ctx_q;
  logic [AW-1:0]       resume_pc_q;
  logic [AW-1:0]       base_addr_q;
  logic [QW-1:0]       tq_value_q;

  logic [NPROC-1:0]    valid_q;
  logic [AW-1:0]       pc_q   [NPROC];
  logic [AW-1:0]       base_q [NPROC];
  logic [QW-1:0]       qtm_q  [NPROC];

  logic [PW-1:0]       free_pid_d;
  logic [PW-1:0]       sel_pid_d;
  logic [PW-1:0]       cand_d;
  logic                sel_found_d;
  logic                create_fire;
  logic [QW-1:0]       sel_qtm;

  assign create_ready_o = ~&valid_q;
  assign create_fire    = create_valid_i & create_ready_o;
  assign sel_qtm        = qtm_q[sel_pid_d];

  // Lowest-index free slot; descending scan so the smallest index wins.
  always_comb begin
    free_pid_d = '0;
    for (int i = NPROC - 1; i >= 0; i--) begin
      if (!valid_q[i]) free_pid_d = PW'(i);
    end
  end

  // First valid slot at start_q, start_q+1, ... (wrapping); descending scan keeps the nearest.
  always_comb begin
    sel_pid_d   = '0;
    sel_found_d = 1'b0;
    cand_d      = '0;
    for (int i = NPROC - 1; i >= 0; i--) begin
      cand_d = start_q + PW'(i);
      if (valid_q[cand_d]) begin
        sel_pid_d   = cand_d;
        sel_found_d = 1'b1;
      end
    end
  end

  // Slot store: creates fill a free slot, SAVE either frees or checkpoints the running slot.
  // A create never targets the running slot because that slot is still valid.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      valid_q <= '0;
      for (int i = 0; i < NPROC; i++) begin
        pc_q[i]   <= '0;
        base_q[i] <= '0;
        qtm_q[i]  <= '0;
      end
    end else begin
      if (create_fire) begin
        valid_q[free_pid_d] <= 1'b1;
        pc_q[free_pid_d]    <= create_pc_i;
        base_q[free_pid_d]  <= create_base_i;
        qtm_q[free_pid_d]   <= create_qtm_i;
      end
      if (state_q == S_SAVE) begin
        if (halt_q) valid_q[cur_pid_q] <= 1'b0;
        else        pc_q[cur_pid_q]    <= save_pc_i;
      end
    end
  end

  // Context-switch FSM; the resume context is registered on the SELECT->LOAD edge so it is
  // valid for the whole ctx cycle and held until the next switch.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q     <= S_IDLE;
      halt_q      <= 1'b0;
      start_q     <= '0;
      cur_pid_q   <= '0;
      ctx_q       <= 1'b0;
      resume_pc_q <= '0;
      base_addr_q <= '0;
      tq_value_q  <= '0;
    end else begin
      ctx_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (|valid_q) begin
            start_q <= '0;
            state_q <= S_SELECT;
          end
        end
        S_RUN: begin
          if (halt_proc_i) begin
            halt_q  <= 1'b1;
            state_q <= S_SAVE;
          end else if (quantum_i) begin
            halt_q  <= 1'b0;
            state_q <= S_SAVE;
          end
        end
        S_SAVE: begin
          start_q <= cur_pid_q + PW'(1);
          state_q <= S_SELECT;
        end
        S_SELECT: begin
          if (sel_found_d) begin
            cur_pid_q   <= sel_pid_d;
            resume_pc_q <= pc_q[sel_pid_d];
            base_addr_q <= base_q[sel_pid_d];
            tq_value_q  <= (sel_qtm == '0) ? QW'(1) : sel_qtm;
            ctx_q       <= 1'b1;
            state_q     <= S_LOAD;
          end else begin
            state_q <= S_IDLE;
          end
        end
        S_LOAD: begin
          state_q <= S_RUN;
        end
        default: begin
          state_q <= S_IDLE;
        end
      endcase
    end
  end

  assign ctx_o       = ctx_q;
  assign tq_load_o   = ctx_q;
  assign resume_pc_o = resume_pc_q;
  assign base_addr_o = base_addr_q;
  assign tq_value_o  = tq_value_q;
  assign cur_pid_o   = cur_pid_q;
  assign running_o   = (state_q == S_RUN);
  assign all_idle_o  = ~|valid_q;

endmodule

// File: tb/tb_process_scheduler.sv
// Bench for process_scheduler: directed vector table, two timing-sensitive sequences,
// then randomized operations checked against a slot-list round-robin reference model.
module tb_process_scheduler;

  localparam int OP_CREATE = 0;
  localparam int OP_QUANT  = 1;
  localparam int OP_HALT   = 2;
  localparam int OP_BOTH   = 3;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        quantum = 1'b0, halt_proc = 1'b0, create_valid = 1'b0;
  logic [31:0] save_pc = '0, create_pc = '0, create_base = '0, create_qtm = '0;
  logic        create_ready, ctx, tq_load, running, all_idle;
  logic [31:0] resume_pc, base_addr, tq_value;
  logic [1:0]  cur_pid;

  always #5 clk = ~clk;

  process_scheduler #(.NPROC(4), .AW(32), .QW(32)) dut (
    .clk_i(clk), .reset_i(reset), .quantum_i(quantum), .halt_proc_i(halt_proc),
    .save_pc_i(save_pc), .create_valid_i(create_valid), .create_ready_o(create_ready),
    .create_pc_i(create_pc), .create_base_i(create_base), .create_qtm_i(create_qtm),
    .ctx_o(ctx), .resume_pc_o(resume_pc), .base_addr_o(base_addr), .tq_load_o(tq_load),
    .tq_value_o(tq_value), .cur_pid_o(cur_pid), .running_o(running), .all_idle_o(all_idle)
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Observations of the most recent do_op call.
  bit          obs_seen, obs_tl_ok;
  int          obs_lat, obs_pulses;
  logic [31:0] obs_pc, obs_base, obs_tq;
  logic [1:0]  obs_pid;

  // Drive one operation for a single clock edge, then watch six cycles for the ctx strobe.
  task automatic do_op(input int op, input logic [31:0] a, b, c);
    @(negedge clk);
    case (op)
      OP_CREATE: begin create_valid = 1'b1; create_pc = a; create_base = b; create_qtm = c; end
      OP_QUANT:  begin quantum = 1'b1; save_pc = a; end
      OP_HALT:   begin halt_proc = 1'b1; end
      default:   begin quantum = 1'b1; halt_proc = 1'b1; save_pc = a; end
    endcase
    @(negedge clk);
    create_valid = 1'b0; quantum = 1'b0; halt_proc = 1'b0;
    obs_seen = 1'b0; obs_tl_ok = 1'b1; obs_lat = 0; obs_pulses = 0;
    obs_pc = '0; obs_base = '0; obs_tq = '0; obs_pid = '0;
    for (int k = 1; k <= 6; k++) begin
      @(negedge clk);
      if (tq_load !== ctx) obs_tl_ok = 1'b0;
      if (ctx === 1'b1) begin
        obs_pulses++;
        if (!obs_seen) begin
          obs_seen = 1'b1; obs_lat = k;
          obs_pc = resume_pc; obs_base = base_addr; obs_tq = tq_value; obs_pid = cur_pid;
        end
      end
    end
  endtask

  task automatic judge(input string tag, input bit ectx, input int epid,
                       input logic [31:0] epc, ebase, etq, input bit erdy, eidle);
    chk({tag, " ctx_seen"}, 32'(obs_seen), 32'(ectx));
    if (ectx) begin
      chk({tag, " ctx_latency"}, obs_lat, 2);
      chk({tag, " ctx_pulses"}, obs_pulses, 1);
      chk({tag, " resume_pc"}, obs_pc, epc);
      chk({tag, " base_addr"}, obs_base, ebase);
      chk({tag, " tq_value"}, obs_tq, etq);
      chk({tag, " pid_at_ctx"}, 32'(obs_pid), 32'(epid));
      chk({tag, " cur_pid_after"}, 32'(cur_pid), 32'(epid));
    end
    chk({tag, " tq_load_eq_ctx"}, 32'(obs_tl_ok), 1);
    chk({tag, " create_ready"}, 32'(create_ready), 32'(erdy));
    chk({tag, " all_idle"}, 32'(all_idle), 32'(eidle));
    chk({tag, " running"}, 32'(running), 32'(!eidle));
  endtask

  typedef struct {
    int op; logic [31:0] a, b, c;
    bit ectx; int epid; logic [31:0] epc, ebase, etq;
    bit erdy, eidle;
  } vec_t;
  vec_t vecs [22];

  // Reference model: per-slot state plus the running slot index.
  bit          m_valid [4];
  logic [31:0] m_pc [4], m_base [4], m_qtm [4];
  int          m_cur;

  task automatic check_reset_values(input string tag);
    chk({tag, " ctx"}, 32'(ctx), 0);
    chk({tag, " tq_load"}, 32'(tq_load), 0);
    chk({tag, " resume_pc"}, resume_pc, 0);
    chk({tag, " base_addr"}, base_addr, 0);
    chk({tag, " tq_value"}, tq_value, 0);
    chk({tag, " cur_pid"}, 32'(cur_pid), 0);
    chk({tag, " running"}, 32'(running), 0);
    chk({tag, " all_idle"}, 32'(all_idle), 1);
    chk({tag, " create_ready"}, 32'(create_ready), 1);
  endtask

  initial begin
    int cnt;
    vecs[0]  = '{OP_CREATE, 32'h100, 32'h1000, 32'd50, 1, 0, 32'h100, 32'h1000, 32'd50, 1, 0};
    vecs[1]  = '{OP_CREATE, 32'h200, 32'h2000, 32'd0,  0, 0, 0, 0, 0, 1, 0};
    vecs[2]  = '{OP_CREATE, 32'h300, 32'h3000, 32'd7,  0, 0, 0, 0, 0, 1, 0};
    vecs[3]  = '{OP_QUANT,  32'h124, 0, 0, 1, 1, 32'h200, 32'h2000, 32'd1,  1, 0};
    vecs[4]  = '{OP_QUANT,  32'h224, 0, 0, 1, 2, 32'h300, 32'h3000, 32'd7,  1, 0};
    vecs[5]  = '{OP_QUANT,  32'h324, 0, 0, 1, 0, 32'h124, 32'h1000, 32'd50, 1, 0};
    vecs[6]  = '{OP_BOTH,   32'h999, 0, 0, 1, 1, 32'h224, 32'h2000, 32'd1,  1, 0};
    vecs[7]  = '{OP_HALT,   0,       0, 0, 1, 2, 32'h324, 32'h3000, 32'd7,  1, 0};
    vecs[8]  = '{OP_QUANT,  32'h444, 0, 0, 1, 2, 32'h444, 32'h3000, 32'd7,  1, 0};
    vecs[9]  = '{OP_HALT,   0,       0, 0, 0, 0, 0, 0, 0, 1, 1};
    vecs[10] = '{OP_CREATE, 32'hA0, 32'hA000, 32'd10, 1, 0, 32'hA0, 32'hA000, 32'd10, 1, 0};
    vecs[11] = '{OP_CREATE, 32'hB0, 32'hB000, 32'd11, 0, 0, 0, 0, 0, 1, 0};
    vecs[12] = '{OP_CREATE, 32'hC0, 32'hC000, 32'd12, 0, 0, 0, 0, 0, 1, 0};
    vecs[13] = '{OP_CREATE, 32'hD0, 32'hD000, 32'd13, 0, 0, 0, 0, 0, 0, 0};
    vecs[14] = '{OP_CREATE, 32'hE0, 32'hE000, 32'd14, 0, 0, 0, 0, 0, 0, 0};
    vecs[15] = '{OP_QUANT,  32'hA4, 0, 0, 1, 1, 32'hB0, 32'hB000, 32'd11, 0, 0};
    vecs[16] = '{OP_QUANT,  32'hB4, 0, 0, 1, 2, 32'hC0, 32'hC000, 32'd12, 0, 0};
    vecs[17] = '{OP_HALT,   0,      0, 0, 1, 3, 32'hD0, 32'hD000, 32'd13, 1, 0};
    vecs[18] = '{OP_CREATE, 32'hF0, 32'hF00, 32'd5, 0, 0, 0, 0, 0, 0, 0};
    vecs[19] = '{OP_QUANT,  32'hD4, 0, 0, 1, 0, 32'hA4, 32'hA000, 32'd10, 0, 0};
    vecs[20] = '{OP_QUANT,  32'hA8, 0, 0, 1, 1, 32'hB4, 32'hB000, 32'd11, 0, 0};
    vecs[21] = '{OP_QUANT,  32'hB8, 0, 0, 1, 2, 32'hF0, 32'hF00,  32'd5,  0, 0};

    repeat (3) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    check_reset_values("reset");

    for (int i = 0; i < 22; i++) begin
      do_op(vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].c);
      judge($sformatf("vec%0d", i), vecs[i].ectx, vecs[i].epid, vecs[i].epc,
            vecs[i].ebase, vecs[i].etq, vecs[i].erdy, vecs[i].eidle);
    end

    // Halt slot 2 with all slots full; a create during SAVE must not take the slot being freed,
    // and a quantum during SELECT must be ignored.
    @(negedge clk); halt_proc = 1'b1;
    @(negedge clk); halt_proc = 1'b0;
    create_valid = 1'b1; create_pc = 32'h77; create_base = 32'h7700; create_qtm = 32'd3;
    chk("save_create_ready", 32'(create_ready), 0);
    @(negedge clk); create_valid = 1'b0; quantum = 1'b1; save_pc = 32'h5555;
    chk("select_no_ctx", 32'(ctx), 0);
    @(negedge clk); quantum = 1'b0;
    chk("halt_ctx", 32'(ctx), 1);
    chk("halt_ctx_pid", 32'(cur_pid), 3);
    chk("halt_ctx_pc", resume_pc, 32'hD4);
    cnt = 0;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      if (ctx === 1'b1) cnt++;
    end
    chk("ignored_quantum_ctx", cnt, 0);
    chk("freed_slot_ready", 32'(create_ready), 1);
    chk("after_halt_running", 32'(running), 1);

    // Reset while in SELECT aborts the switch.
    @(negedge clk); quantum = 1'b1; save_pc = 32'h55;
    @(negedge clk); quantum = 1'b0;
    @(negedge clk); reset = 1'b1;
    @(negedge clk); reset = 1'b0;
    cnt = 0;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      if (ctx === 1'b1) cnt++;
    end
    chk("abort_ctx_count", cnt, 0);
    check_reset_values("abort");

    // Randomized operations against the reference model (DUT is freshly reset).
    for (int s = 0; s < 4; s++) begin
      m_valid[s] = 1'b0; m_pc[s] = '0; m_base[s] = '0; m_qtm[s] = '0;
    end
    m_cur = 0;
    for (int n = 0; n < 200; n++) begin
      int op, r, nxt, nvalid, slot;
      bit ectx;
      logic [31:0] a, b, c;
      nvalid = 0;
      for (int s = 0; s < 4; s++) nvalid += int'(m_valid[s]);
      r  = $urandom_range(0, 9);
      op = (nvalid == 0 || r < 4) ? OP_CREATE : (r < 7) ? OP_QUANT : (r < 9) ? OP_HALT : OP_BOTH;
      a = $urandom; b = $urandom;
      c = ($urandom_range(0, 3) == 0) ? 32'd0 : 32'($urandom_range(1, 1000));
      ectx = 1'b0;
      if (op == OP_CREATE) begin
        slot = -1;
        for (int s = 3; s >= 0; s--) if (!m_valid[s]) slot = s;
        if (slot >= 0) begin
          m_valid[slot] = 1'b1; m_pc[slot] = a; m_base[slot] = b; m_qtm[slot] = c;
          if (nvalid == 0) begin ectx = 1'b1; m_cur = slot; end
        end
      end else begin
        if (op == OP_QUANT) m_pc[m_cur] = a;
        else                m_valid[m_cur] = 1'b0;
        nxt = -1;
        for (int k = 4; k >= 1; k--) if (m_valid[(m_cur + k) % 4]) nxt = (m_cur + k) % 4;
        if (nxt >= 0) begin ectx = 1'b1; m_cur = nxt; end
      end
      do_op(op, a, b, c);
      nvalid = 0;
      for (int s = 0; s < 4; s++) nvalid += int'(m_valid[s]);
      judge($sformatf("rnd%0d", n), ectx, m_cur, m_pc[m_cur], m_base[m_cur],
            (m_qtm[m_cur] == 0) ? 32'd1 : m_qtm[m_cur], nvalid < 4, nvalid == 0);
      if (nvalid != 0) chk($sformatf("rnd%0d cur_pid", n), 32'(cur_pid), 32'(m_cur));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
